// File: rtl/chacha_pkg.sv
// Shared types for the ChaCha20 keystream serializer: word type, block size, FSM state encoding.
package chacha_pkg;

   typedef logic [31:0] word_t;

   localparam int unsigned NWORDS = 16;
   localparam int unsigned IDX_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DONE
   } ser_state_e;

endpackage

// File: rtl/chacha_word_buffer.sv
// Capture register for one 4x4 ChaCha20 state matrix with a row-major word read mux.
module chacha_word_buffer
   import chacha_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   capture,
   input  word_t [3:0][3:0]       matrix_in,
   input  logic  [IDX_W-1:0]      idx,
   output word_t                  word_out
);

   word_t [3:0][3:0] mat_q;
   word_t [3:0][3:0] mat_d;

   always_comb begin
      mat_d = mat_q;
      if (capture) begin
         mat_d = matrix_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mat_q <= '0;
      end else begin
         mat_q <= mat_d;
      end
   end

   // idx = 4*row + col, so the upper two bits pick the row
   always_comb begin
      word_out = mat_q[idx[3:2]][idx[1:0]];
   end

endmodule

// File: rtl/chacha_keystream_serializer.sv
// Streams one captured ChaCha20 block as 16 keystream words over valid/ready and pulses blockready when done.
// Optional CHACHA_SER_XOR_EN adds pt_word/ct_word for in-line encryption.
module chacha_keystream_serializer #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned NWORDS = 16,
   parameter int unsigned CNT_W  = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  chacha_pkg::word_t [3:0][3:0]  matrix_in,
   input  logic                          matrix_valid,
   output logic                          matrix_ready,
   input  logic                          flush,
`ifdef CHACHA_SER_XOR_EN
   input  logic [WORD_W-1:0]             pt_word,
   output logic [WORD_W-1:0]             ct_word,
`endif
   output logic [WORD_W-1:0]             ks_word,
   output logic                          ks_valid,
   input  logic                          ks_ready,
   output logic                          ks_last,
   output logic                          blockready,
   output logic [CNT_W-1:0]              blocks_sent,
   output logic                          ctr_wrap
);

   import chacha_pkg::*;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

   ser_state_e        state_q;
   ser_state_e        state_d;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  idx_d;
   logic [CNT_W-1:0]  blocks_sent_q;
   logic [CNT_W-1:0]  blocks_sent_d;
   logic              ctr_wrap_q;
   logic              ctr_wrap_d;

   logic              capture;
   logic              handshake;
   word_t             buf_word;

   chacha_word_buffer u_buf (
      .clk       (clk),
      .rst       (rst),
      .capture   (capture),
      .matrix_in (matrix_in),
      .idx       (idx_q),
      .word_out  (buf_word)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // flush wins over a same-cycle handshake, so it is tested first
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (matrix_valid) begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (flush) begin
               state_d = IDLE;
            end else if (handshake && (idx_q == IDX_LAST)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      matrix_ready = (state_q == IDLE) && rst;
      capture      = (state_q == IDLE) && rst && matrix_valid;
      ks_valid     = (state_q == STREAM);
      ks_last      = (state_q == STREAM) && (idx_q == IDX_LAST);
      blockready   = (state_q == DONE);
      handshake    = ks_valid && ks_ready;
   end

   always_comb begin
      idx_d         = idx_q;
      blocks_sent_d = blocks_sent_q;
      ctr_wrap_d    = ctr_wrap_q;
      if (capture) begin
         idx_d = '0;
      end else if ((state_q == STREAM) && !flush && handshake) begin
         idx_d = idx_q + IDX_W'(1);
      end
      if (state_q == DONE) begin
         blocks_sent_d = blocks_sent_q + CNT_W'(1);
         if (blocks_sent_q == '1) begin
            ctr_wrap_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_q         <= '0;
         blocks_sent_q <= '0;
         ctr_wrap_q    <= 1'b0;
      end else begin
         idx_q         <= idx_d;
         blocks_sent_q <= blocks_sent_d;
         ctr_wrap_q    <= ctr_wrap_d;
      end
   end

   assign ks_word     = WORD_W'(buf_word);
   assign blocks_sent = blocks_sent_q;
   assign ctr_wrap    = ctr_wrap_q;

`ifdef CHACHA_SER_XOR_EN
   assign ct_word = pt_word ^ ks_word;
`endif

endmodule

// File: tb/tb_chacha_keystream_serializer.sv
// Directed self-checking bench for chacha_keystream_serializer using the RFC 8439 block-function test vector.
module tb_chacha_keystream_serializer;
   import chacha_pkg::*;

   logic              clk;
   logic              rst;
   word_t [3:0][3:0]  matrix_in;
   logic              matrix_valid;
   logic              matrix_ready;
   logic              flush;
   logic [31:0]       ks_word;
   logic              ks_valid;
   logic              ks_ready;
   logic              ks_last;
   logic              blockready;
   logic [31:0]       blocks_sent;
   logic              ctr_wrap;
`ifdef CHACHA_SER_XOR_EN
   logic [31:0]       pt_word;
   logic [31:0]       ct_word;
`endif

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   word_t rfc_w [16];
   word_t alt_w [16];

   chacha_keystream_serializer #(
      .WORD_W (32),
      .NWORDS (16),
      .CNT_W  (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .matrix_in    (matrix_in),
      .matrix_valid (matrix_valid),
      .matrix_ready (matrix_ready),
      .flush        (flush),
`ifdef CHACHA_SER_XOR_EN
      .pt_word      (pt_word),
      .ct_word      (ct_word),
`endif
      .ks_word      (ks_word),
      .ks_valid     (ks_valid),
      .ks_ready     (ks_ready),
      .ks_last      (ks_last),
      .blockready   (blockready),
      .blocks_sent  (blocks_sent),
      .ctr_wrap     (ctr_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic load_matrix(input bit use_alt);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            matrix_in[r][c] = use_alt ? alt_w[4*r+c] : rfc_w[4*r+c];
         end
      end
   endtask

   // Called at a negedge while IDLE; returns at the negedge where the block is streaming.
   task automatic capture_block(input bit use_alt);
      check("matrix_ready_idle", 32'(matrix_ready), 32'd1);
      load_matrix(use_alt);
      matrix_valid = 1'b1;
      @(negedge clk);
      matrix_valid = 1'b0;
   endtask

   // Streams n_words handshakes starting at word index start, optionally with random stalls.
   task automatic stream_words(input bit use_alt, input bit rnd, input int unsigned start,
                               input int unsigned n_words, output int unsigned cycles);
      int unsigned got;
      logic [31:0] prev_w;
      bit          stalled;
      logic [31:0] e;
      got     = start;
      prev_w  = '0;
      stalled = 1'b0;
      cycles  = 0;
      while ((got < start + n_words) && (cycles < 400)) begin
         e = use_alt ? alt_w[got] : rfc_w[got];
         check("ks_valid", 32'(ks_valid), 32'd1);
         check("ks_word", ks_word, e);
         check("ks_last", 32'(ks_last), 32'(got == 15));
         check("blockready_stream", 32'(blockready), 32'd0);
         if (stalled) begin
            check("stall_stable", ks_word, prev_w);
         end
`ifdef CHACHA_SER_XOR_EN
         pt_word = $urandom;
         #1;
         check("ct_word", ct_word, pt_word ^ e);
`endif
         ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         prev_w   = ks_word;
         stalled  = !ks_ready;
         if (ks_ready) begin
            got++;
         end
         cycles++;
         @(negedge clk);
      end
      ks_ready = 1'b0;
      if (got < start + n_words) begin
         check("stream_timeout", got, start + n_words);
      end
   endtask

   // Called at the negedge in DONE; returns at the following negedge in IDLE.
   task automatic finish_block(input logic [31:0] exp_count);
      check("blockready_done", 32'(blockready), 32'd1);
      check("ks_valid_done", 32'(ks_valid), 32'd0);
      check("matrix_ready_done", 32'(matrix_ready), 32'd0);
      @(negedge clk);
      check("blockready_pulse", 32'(blockready), 32'd0);
      check("blocks_sent", blocks_sent, exp_count);
      check("matrix_ready_after", 32'(matrix_ready), 32'd1);
   endtask

   initial begin
      int unsigned cyc;
      rfc_w = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
      alt_w = '{32'h0000_0001, 32'h1111_1112, 32'h2222_2223, 32'h3333_3334,
                32'h4444_4445, 32'h5555_5556, 32'h6666_6667, 32'h7777_7778,
                32'h8888_8889, 32'h9999_999a, 32'haaaa_aaab, 32'hbbbb_bbbc,
                32'hcccc_cccd, 32'hdddd_ddde, 32'heeee_eeef, 32'hffff_fff0};
      rst          = 1'b0;
      matrix_in    = '0;
      matrix_valid = 1'b0;
      flush        = 1'b0;
      ks_ready     = 1'b0;
`ifdef CHACHA_SER_XOR_EN
      pt_word      = '0;
`endif
      @(negedge clk);
      @(negedge clk);
      check("rst_matrix_ready", 32'(matrix_ready), 32'd0);
      check("rst_ks_valid", 32'(ks_valid), 32'd0);
      check("rst_ks_last", 32'(ks_last), 32'd0);
      check("rst_blockready", 32'(blockready), 32'd0);
      check("rst_blocks_sent", blocks_sent, 32'd0);
      check("rst_ctr_wrap", 32'(ctr_wrap), 32'd0);
      check("rst_ks_word", ks_word, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // 1: RFC vector, ready always high
      capture_block(1'b0);
      stream_words(1'b0, 1'b0, 0, 16, cyc);
      check("t1_cycles", cyc, 32'd16);
      finish_block(32'd1);

      // 2: random backpressure
      capture_block(1'b0);
      stream_words(1'b0, 1'b1, 0, 16, cyc);
      finish_block(32'd2);

      // 3: matrix_valid held with a different matrix during streaming
      capture_block(1'b0);
      load_matrix(1'b1);
      matrix_valid = 1'b1;
      stream_words(1'b0, 1'b0, 0, 16, cyc);
      finish_block(32'd3);
      @(negedge clk);
      matrix_valid = 1'b0;
      stream_words(1'b1, 1'b0, 0, 16, cyc);
      finish_block(32'd4);

      // 4: flush at idx 7 coincident with a handshake
      capture_block(1'b0);
      stream_words(1'b0, 1'b0, 0, 7, cyc);
      check("t4_word7", ks_word, rfc_w[7]);
      flush    = 1'b1;
      ks_ready = 1'b1;
      @(negedge clk);
      flush    = 1'b0;
      ks_ready = 1'b0;
      check("t4_ks_valid", 32'(ks_valid), 32'd0);
      check("t4_blockready", 32'(blockready), 32'd0);
      check("t4_blocks_sent", blocks_sent, 32'd4);
      @(negedge clk);
      check("t4_blockready_late", 32'(blockready), 32'd0);
      capture_block(1'b1);
      stream_words(1'b1, 1'b0, 0, 16, cyc);
      finish_block(32'd5);

      // 5: counter wrap
      force dut.blocks_sent_q = 32'hffff_ffff;
      @(negedge clk);
      release dut.blocks_sent_q;
      check("t5_preload", blocks_sent, 32'hffff_ffff);
      capture_block(1'b0);
      stream_words(1'b0, 1'b0, 0, 16, cyc);
      finish_block(32'd0);
      check("t5_ctr_wrap", 32'(ctr_wrap), 32'd1);
      capture_block(1'b1);
      stream_words(1'b1, 1'b0, 0, 16, cyc);
      finish_block(32'd1);
      check("t5_ctr_wrap_sticky", 32'(ctr_wrap), 32'd1);

      // 6: one-cycle reset at idx 10
      capture_block(1'b0);
      stream_words(1'b0, 1'b0, 0, 10, cyc);
      check("t6_word10", ks_word, rfc_w[10]);
      rst      = 1'b0;
      ks_ready = 1'b1;
      @(negedge clk);
      ks_ready = 1'b0;
      check("t6_ks_valid", 32'(ks_valid), 32'd0);
      check("t6_ks_word", ks_word, 32'd0);
      check("t6_ks_last", 32'(ks_last), 32'd0);
      check("t6_blockready", 32'(blockready), 32'd0);
      check("t6_blocks_sent", blocks_sent, 32'd0);
      check("t6_ctr_wrap", 32'(ctr_wrap), 32'd0);
      check("t6_matrix_ready_rst", 32'(matrix_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("t6_matrix_ready", 32'(matrix_ready), 32'd1);
      check("t6_blockready_after", 32'(blockready), 32'd0);
      capture_block(1'b1);
      stream_words(1'b1, 1'b0, 0, 16, cyc);
      finish_block(32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
